sobel_window: RTL and testbench
===============================

SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 Parameter WIDTH_P, default 8, pixel and gradient width in bits.
REQ-002 Parameter LINE_W_P, default 640, pixels per image line; legal range 3..65535.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  one pixel column is presented on row0_i/row1_i/row2_i.
REQ-006 ready_o  output  1  block accepts the column this cycle.
REQ-007 row0_i  input  WIDTH_P  top-row pixel of the column, unsigned.
REQ-008 row1_i  input  WIDTH_P  middle-row pixel, unsigned.
REQ-009 row2_i  input  WIDTH_P  bottom-row pixel, unsigned.
REQ-010 valid_o  output  1  gx_o/gy_o/eol_o hold a result.
REQ-011 ready_i  input  1  downstream (magnitude stage) accepts the result.
REQ-012 gx_o  output  WIDTH_P  |Gx| saturated, unsigned.
REQ-013 gy_o  output  WIDTH_P  |Gy| saturated, unsigned.
REQ-014 eol_o  output  1  result belongs to the last column of a line.

Function
REQ-015 Pipeline enable en = !valid_o || ready_i; ready_o SHALL equal en combinationally.
REQ-016 Accept = valid_i && en; all state SHALL hold when en is low.
REQ-017 Window: two column registers C0 (older) and C1 (newer), each three pixels; on accept C0<=C1, C1<=incoming column N.
REQ-018 Column counter col, 0..LINE_W_P-1, SHALL increment on accept and wrap LINE_W_P-1 -> 0.
REQ-019 Stage 1 on en: v1 <= accept && (col >= 2); when loaded, store signed sums from window (C0, C1, N) using pre-update C0/C1.
REQ-020 Gx = (N.r0 + 2*N.r1 + N.r2) - (C0.r0 + 2*C0.r1 + C0.r2), signed, WIDTH_P+3 bits, no overflow.
REQ-021 Gy = (C0.r0 + 2*C1.r0 + N.r0) - (C0.r2 + 2*C1.r2 + N.r2), signed, WIDTH_P+3 bits.
REQ-022 Stage 1 SHALL register eol1 <= accept && (col == LINE_W_P-1).
REQ-023 Stage 2 on en: valid_o <= v1; gx_o <= sat(|Gx|); gy_o <= sat(|Gy|); eol_o <= eol1.
REQ-024 sat(x) = x if x <= 2^WIDTH_P-1, else 2^WIDTH_P-1.
REQ-025 Latency: column accepted at edge E with valid_o low throughout yields valid_o high after edge E+1.
REQ-026 Columns 0 and 1 of each line SHALL produce no output; LINE_W_P-2 results per line, no border padding.
REQ-027 Window history SHALL not be cleared at line wrap; suppression by col alone ensures no cross-line windows are emitted.
REQ-028 While valid_o && !ready_i, gx_o/gy_o/eol_o SHALL be stable and no input accepted.
REQ-029 valid_o SHALL not depend combinationally on valid_i or ready_i.
REQ-030 Throughput: one column per cycle when ready_i held high.

Reset
REQ-031 When rst_i is high at a rising edge: col=0, v1=0, eol1=0, valid_o=0, gx_o=0, gy_o=0, eol_o=0, C0=C1=0, stage-1 sums=0.
REQ-032 Reset mid-operation SHALL discard in-flight results; next accepted column is column 0 of a new line.
REQ-033 ready_o SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 Flat field: LINE_W_P=8, all pixels 100, ready_i=1 -> 6 results per line, gx_o=gy_o=0, eol_o=1 only on the 6th.
REQ-035 Vertical step: columns 0,1 all 0, column 2 all 255, WIDTH_P=8 -> first result gx_o=255 (1020 saturated), gy_o=0.
REQ-036 Horizontal edge: each column r0=0, r1=0, r2=60 -> gx_o=0, gy_o=240 (|-240|, no saturation).
REQ-037 Backpressure: ready_i low 5 cycles during a streaming line -> ready_o low while valid_o high, outputs frozen, no result lost or duplicated; sequence matches golden model.
REQ-038 Line wrap: LINE_W_P=4, 12 columns streamed -> exactly 6 results, eol_o on results 2, 4, 6; no window spans a line boundary.
REQ-039 Reset mid-line: rst_i pulsed after column 5 with valid_o high -> valid_o=0 next cycle; subsequent columns 0,1 produce no output, column 2 produces a result.

Source files
------------

// File: rtl/sobel_window.sv
// sobel_window
// 3x3 Sobel gradient stage over a stream of pixel columns. Each accepted
// column carries the top/middle/bottom pixel of one image column. A sliding
// window of the two previous columns plus the incoming one forms the 3x3
// neighbourhood. The block produces saturated |Gx| and |Gy| two pipeline
// stages later. The first two columns of each line are suppressed, so no
// window ever straddles a line boundary. A single enable stalls the whole
// pipeline under backpressure.
module sobel_window #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] row0_i,
  input  logic [WIDTH_P-1:0] row1_i,
  input  logic [WIDTH_P-1:0] row2_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] gx_o,
  output logic [WIDTH_P-1:0] gy_o,
  output logic               eol_o
);

  // Column counter must hold the constant 2 even for the narrowest line.
  localparam int COL_W = (LINE_W_P > 4) ? $clog2(LINE_W_P) : 2;
  // A weighted 1-2-1 sum of three pixels needs two extra bits. A
  // difference of two such sums needs one more bit for the sign.
  localparam int WSUM_W = WIDTH_P + 2;
  localparam int SUM_W  = WIDTH_P + 3;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_W_P - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);

  logic en;
  logic accept;

  // Window registers: c0 is the older column, c1 is the newer one.
  logic [WIDTH_P-1:0] c0_r0, c0_r1, c0_r2;
  logic [WIDTH_P-1:0] c1_r0, c1_r1, c1_r2;
  logic [COL_W-1:0]   col;

  // Stage 1: signed gradients and their side-band flags.
  logic                    v1;
  logic                    eol1;
  logic signed [SUM_W-1:0] gx_s1;
  logic signed [SUM_W-1:0] gy_s1;

  // Combinational gradient terms, built from the pre-update window.
  logic [WSUM_W-1:0]       wx_new, wx_old;
  logic [WSUM_W-1:0]       wy_top, wy_bot;
  logic signed [SUM_W-1:0] gx_nxt, gy_nxt;

  assign en      = !valid_o || ready_i;
  assign ready_o = en;
  assign accept  = valid_i && en;

  // |x| clamped to the pixel range. The sums are bounded by design, so
  // negating the most negative value can never occur.
  function automatic logic [WIDTH_P-1:0] abs_sat(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-1:0] mag;
    mag = v[SUM_W-1] ? SUM_W'(-v) : SUM_W'(v);
    if (|mag[SUM_W-1:WIDTH_P]) begin
      abs_sat = '1;
    end else begin
      abs_sat = mag[WIDTH_P-1:0];
    end
  endfunction

  // Gradient arithmetic: Gx is the horizontal difference, Gy the vertical.
  always_comb begin
    wx_new = {2'b00, row0_i} + {1'b0, row1_i, 1'b0} + {2'b00, row2_i};
    wx_old = {2'b00, c0_r0}  + {1'b0, c0_r1, 1'b0}  + {2'b00, c0_r2};
    wy_top = {2'b00, c0_r0}  + {1'b0, c1_r0, 1'b0}  + {2'b00, row0_i};
    wy_bot = {2'b00, c0_r2}  + {1'b0, c1_r2, 1'b0}  + {2'b00, row2_i};
    gx_nxt = $signed({1'b0, wx_new}) - $signed({1'b0, wx_old});
    gy_nxt = $signed({1'b0, wy_top}) - $signed({1'b0, wy_bot});
  end

  // Window shift and column position. History is kept across line wraps.
  // The col-based suppression alone keeps cross-line windows out of the output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c0_r0 <= '0;
      c0_r1 <= '0;
      c0_r2 <= '0;
      c1_r0 <= '0;
      c1_r1 <= '0;
      c1_r2 <= '0;
      col   <= '0;
    end else if (accept) begin
      c0_r0 <= c1_r0;
      c0_r1 <= c1_r1;
      c0_r2 <= c1_r2;
      c1_r0 <= row0_i;
      c1_r1 <= row1_i;
      c1_r2 <= row2_i;
      col   <= (col == COL_LAST) ? '0 : col + COL_W'(1);
    end
  end

  // Stage 1: capture the gradients of complete windows only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1    <= 1'b0;
      eol1  <= 1'b0;
      gx_s1 <= '0;
      gy_s1 <= '0;
    end else if (en) begin
      v1   <= accept && (col >= COL_FIRST);
      eol1 <= accept && (col == COL_LAST);
      if (accept && (col >= COL_FIRST)) begin
        gx_s1 <= gx_nxt;
        gy_s1 <= gy_nxt;
      end
    end
  end

  // Stage 2: take magnitudes, saturate, and hold the result under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      gx_o    <= '0;
      gy_o    <= '0;
      eol_o   <= 1'b0;
    end else if (en) begin
      valid_o <= v1;
      gx_o    <= abs_sat(gx_s1);
      gy_o    <= abs_sat(gy_s1);
      eol_o   <= eol1;
    end
  end

endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window with an 8-pixel line and 8-bit pixels.
// Expected gradients are hand-computed per column. A two-entry shadow of
// the pipeline (pending result, shown result) tracks what the outputs should hold.
module tb_sobel_window;

  localparam int W = 8;
  localparam int L = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] row0_i, row1_i, row2_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] gx_o, gy_o;
  logic         eol_o;

  sobel_window #(.WIDTH_P(W), .LINE_W_P(L)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .row0_i  (row0_i),
    .row1_i  (row1_i),
    .row2_i  (row2_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .gx_o    (gx_o),
    .gy_o    (gy_o),
    .eol_o   (eol_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  // Shadow pipeline state.
  int           col_idx = 0;
  logic         pend_v = 1'b0, pend_eol = 1'b0;
  logic [W-1:0] pend_gx = '0, pend_gy = '0;
  logic         sh_v = 1'b0, sh_eol = 1'b0;
  logic [W-1:0] sh_gx = '0, sh_gy = '0;

  // Line D: mixed pixel values with hand-derived gradients.
  logic [W-1:0] d_r0 [8] = '{8'd10, 8'd40, 8'd5, 8'd200, 8'd0, 8'd1, 8'd7, 8'd0};
  logic [W-1:0] d_r1 [8] = '{8'd20, 8'd50, 8'd5, 8'd0,   8'd0, 8'd2, 8'd7, 8'd100};
  logic [W-1:0] d_r2 [8] = '{8'd30, 8'd60, 8'd5, 8'd0,   8'd0, 8'd3, 8'd7, 8'd0};
  logic [W-1:0] d_gx [8] = '{8'd0,  8'd0,  8'd60, 8'd0,   8'd20,  8'd192, 8'd28, 8'd192};
  logic [W-1:0] d_gy [8] = '{8'd0,  8'd0,  8'd60, 8'd180, 8'd255, 8'd198, 8'd4,  8'd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid_o"}, 32'(valid_o), 32'(sh_v));
    if (sh_v) begin
      chk({tag, ".gx_o"},  32'(gx_o),  32'(sh_gx));
      chk({tag, ".gy_o"},  32'(gy_o),  32'(sh_gy));
      chk({tag, ".eol_o"}, 32'(eol_o), 32'(sh_eol));
    end else begin
      chk({tag, ".eol_o"}, 32'(eol_o), 32'd0);
    end
  endtask

  task automatic shift_model(input logic nv, input logic [W-1:0] egx, input logic [W-1:0] egy,
                             input logic neol);
    sh_v     = pend_v;
    sh_gx    = pend_gx;
    sh_gy    = pend_gy;
    sh_eol   = pend_eol;
    pend_v   = nv;
    pend_gx  = egx;
    pend_gy  = egy;
    pend_eol = neol;
  endtask

  // Present one column with ready_i high; it is accepted at the next edge.
  task automatic push(input string tag, input logic [W-1:0] r0, input logic [W-1:0] r1,
                      input logic [W-1:0] r2, input logic [W-1:0] egx, input logic [W-1:0] egy);
    valid_i = 1'b1;
    ready_i = 1'b1;
    row0_i  = r0;
    row1_i  = r1;
    row2_i  = r2;
    @(posedge clk_i); #1;
    shift_model(col_idx >= 2, egx, egy, col_idx == L - 1);
    col_idx = (col_idx == L - 1) ? 0 : col_idx + 1;
    check_out(tag);
    chk({tag, ".ready_o"}, 32'(ready_o), 32'd1);
  endtask

  task automatic idle(input string tag);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    shift_model(1'b0, '0, '0, 1'b0);
    check_out(tag);
  endtask

  // Offer a column while the downstream refuses: nothing may move.
  task automatic stall(input string tag, input logic [W-1:0] r0, input logic [W-1:0] r1,
                       input logic [W-1:0] r2);
    valid_i = 1'b1;
    ready_i = 1'b0;
    row0_i  = r0;
    row1_i  = r1;
    row2_i  = r2;
    @(posedge clk_i); #1;
    check_out(tag);
    chk({tag, ".ready_o"}, 32'(ready_o), 32'd0);
    ready_i = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    sh_v = 1'b0; sh_gx = '0; sh_gy = '0; sh_eol = 1'b0;
    pend_v = 1'b0; pend_gx = '0; pend_gy = '0; pend_eol = 1'b0;
    col_idx = 0;
    check_out(tag);
    chk({tag, ".gx_o"}, 32'(gx_o), 32'd0);
    chk({tag, ".gy_o"}, 32'(gy_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk({tag, ".ready_after_rst"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    row0_i  = '0;
    row1_i  = '0;
    row2_i  = '0;
    @(posedge clk_i); #1;
    do_reset("reset");

    // Flat field: zero gradients, eol only on the last result of the line.
    for (int k = 0; k < L; k++) push("flat", 8'd100, 8'd100, 8'd100, 8'd0, 8'd0);

    // Vertical step: columns 2 and 3 see 0|255 transitions (1020 saturates).
    for (int k = 0; k < L; k++) begin
      if (k < 2) push("vstep", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      else push("vstep", 8'd255, 8'd255, 8'd255, (k < 4) ? 8'd255 : 8'd0, 8'd0);
    end

    // Horizontal edge: Gy = -240 on every result, no saturation.
    for (int k = 0; k < L; k++) push("hedge", 8'd0, 8'd0, 8'd60, 8'd0, 8'd240);

    // Mixed line with a 5-cycle downstream stall in the middle.
    for (int k = 0; k < 5; k++) push("mixed", d_r0[k], d_r1[k], d_r2[k], d_gx[k], d_gy[k]);
    for (int s = 0; s < 5; s++) stall("stall", d_r0[5], d_r1[5], d_r2[5]);
    for (int k = 5; k < L; k++) push("mixed", d_r0[k], d_r1[k], d_r2[k], d_gx[k], d_gy[k]);
    idle("drain");
    idle("drain");

    // Reset mid-line while a result is on the output.
    for (int k = 0; k < 6; k++) push("pre_rst", d_r0[k], d_r1[k], d_r2[k], d_gx[k], d_gy[k]);
    chk("pre_rst.valid_high", 32'(valid_o), 32'd1);
    do_reset("mid_rst");
    for (int k = 0; k < 3; k++) push("post_rst", d_r0[k], d_r1[k], d_r2[k], d_gx[k], d_gy[k]);
    idle("post_rst_drain");
    idle("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
